// File: rtl/multi_port_mem_ctrl_pkg.sv
// Shared definitions for the multi-channel byte-serial memory/IO controller:
// state encoding, IO page select, length field width and byte-count helpers.
package multi_port_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam logic [1:0] IO_PAGE = 2'b11;
    localparam int         LEN_W   = 3;

    function automatic int maxb_of(input int dat_w);
        return dat_w / 8;
    endfunction

    // Zero or oversize requests move a full word.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int maxb);
        logic [LEN_W-1:0] res;
        if ((len == {LEN_W{1'b0}}) || (int'(len) > maxb)) begin
            res = LEN_W'(maxb);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_port_mem_ctrl_if.sv
// Requester channels plus the shared byte-serial RAM/IO bus; the controller
// uses the slave view, the requesters and memory model use the master view.
interface multi_port_mem_ctrl_if #(
    parameter int NCH   = 3,
    parameter int ADR_W = 18,
    parameter int DAT_W = 32
) ();
    import multi_port_mem_ctrl_pkg::*;

    logic [NCH-1:0]       req_en_i;
    logic [NCH-1:0]       req_rw_i;
    logic [NCH*LEN_W-1:0] req_len_i;
    logic [NCH*ADR_W-1:0] req_adr_i;
    logic [NCH*DAT_W-1:0] req_dat_i;
    logic [NCH-1:0]       gnt_o;
    logic [NCH-1:0]       resp_en_o;
    logic [DAT_W-1:0]     resp_dat_o;
    logic [7:0]           ram_dat_i;
    logic [7:0]           ram_dat_o;
    logic [ADR_W-1:0]     ram_adr_o;
    logic                 ram_rwen_o;
    logic                 iob_full_i;
    logic                 flush_i;

    modport master (
        output req_en_i, req_rw_i, req_len_i, req_adr_i, req_dat_i,
        output ram_dat_i, iob_full_i, flush_i,
        input  gnt_o, resp_en_o, resp_dat_o, ram_dat_o, ram_adr_o, ram_rwen_o
    );

    modport slave (
        input  req_en_i, req_rw_i, req_len_i, req_adr_i, req_dat_i,
        input  ram_dat_i, iob_full_i, flush_i,
        output gnt_o, resp_en_o, resp_dat_o, ram_dat_o, ram_adr_o, ram_rwen_o
    );

endinterface

// File: rtl/multi_port_mem_ctrl_rr_arbiter.sv
// Combinational channel arbiter: round-robin from ptr+1 (RR=1) or lowest index
// first (RR=0). The pointer register itself lives in the parent.
module multi_port_mem_ctrl_rr_arbiter #(
    parameter int NCH = 3,
    parameter bit RR  = 1'b1,
    parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] elig,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [PW-1:0]  next_ptr
);

    logic [NCH-1:0] cand_s;
    logic           found_s;
    logic           hit_s;
    int             idx_s;

    // Walk candidates in priority order and keep the first eligible requester.
    always_comb begin
        cand_s   = req & elig;
        grant    = {NCH{1'b0}};
        next_ptr = ptr;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        idx_s    = 0;
        for (int k = 0; k < NCH; k++) begin
            idx_s = RR ? (int'(ptr) + 1 + k) : k;
            idx_s = (idx_s >= NCH) ? (idx_s - NCH) : idx_s;
            for (int i = 0; i < NCH; i++) begin
                hit_s    = ~found_s & cand_s[i] & (i == idx_s);
                grant[i] = grant[i] | hit_s;
                next_ptr = hit_s ? PW'(i) : next_ptr;
                found_s  = found_s | hit_s;
            end
        end
    end

endmodule

// File: rtl/multi_port_mem_ctrl.sv
// Arbitrates NCH requester channels onto one byte-serial RAM/IO bus; each grant
// moves 1..MAXB little-endian bytes, with flush abort and UART back-pressure.
module multi_port_mem_ctrl
    import multi_port_mem_ctrl_pkg::*;
#(
    parameter int             NCH        = 3,
    parameter int             ADR_W      = 18,
    parameter int             DAT_W      = 32,
    parameter bit             RR         = 1'b1,
    parameter logic [NCH-1:0] FLUSH_MASK = NCH'(3'b011)
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  en,
    multi_port_mem_ctrl_if.slave bus
);

    localparam int MAXB = maxb_of(DAT_W);
    localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;

    state_e           state_r;
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    ch_r;
    logic             io_wr_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt_r;
    logic [ADR_W-1:0] adr_r;
    logic [DAT_W-1:0] wdat_r;
    logic [DAT_W-1:0] rdat_r;
    logic [NCH-1:0]   gnt_r;
    logic [NCH-1:0]   resp_en_r;
    logic [DAT_W-1:0] resp_dat_r;
    logic [7:0]       ram_dat_r;
    logic             rwen_r;

    logic [NCH-1:0]   elig_s;
    logic [NCH-1:0]   grant_s;
    logic [PW-1:0]    next_ptr_s;
    logic             sel_rw_s;
    logic [LEN_W-1:0] sel_len_s;
    logic [ADR_W-1:0] sel_adr_s;
    logic [DAT_W-1:0] sel_dat_s;
    logic [DAT_W-1:0] rdat_next_s;
    logic             last_s;
    logic             abort_s;
    logic             stall_s;

    assign elig_s  = ~(FLUSH_MASK & {NCH{bus.flush_i}});
    assign last_s  = (cnt_r == (len_r - LEN_W'(1'b1)));
    assign abort_s = bus.flush_i & FLUSH_MASK[ch_r];
    assign stall_s = io_wr_r & bus.iob_full_i;

    multi_port_mem_ctrl_rr_arbiter #(
        .NCH (NCH),
        .RR  (RR),
        .PW  (PW)
    ) u_rr_arbiter (
        .req      (bus.req_en_i),
        .elig     (elig_s),
        .ptr      (ptr_r),
        .grant    (grant_s),
        .next_ptr (next_ptr_s)
    );

    // Route the winning channel's request fields (grant is one-hot).
    always_comb begin
        sel_rw_s  = 1'b0;
        sel_len_s = {LEN_W{1'b0}};
        sel_adr_s = {ADR_W{1'b0}};
        sel_dat_s = {DAT_W{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            sel_rw_s  = sel_rw_s  | (bus.req_rw_i[i] & grant_s[i]);
            sel_len_s = sel_len_s | (bus.req_len_i[i*LEN_W +: LEN_W] & {LEN_W{grant_s[i]}});
            sel_adr_s = sel_adr_s | (bus.req_adr_i[i*ADR_W +: ADR_W] & {ADR_W{grant_s[i]}});
            sel_dat_s = sel_dat_s | (bus.req_dat_i[i*DAT_W +: DAT_W] & {DAT_W{grant_s[i]}});
        end
    end

    // Drop the returned RAM byte into the lane selected by the byte counter.
    always_comb begin
        rdat_next_s = rdat_r;
        for (int b = 0; b < MAXB; b++) begin
            rdat_next_s[b*8 +: 8] = (cnt_r == LEN_W'(b)) ? bus.ram_dat_i : rdat_r[b*8 +: 8];
        end
    end

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PW'(NCH - 1);
            ch_r       <= {PW{1'b0}};
            io_wr_r    <= 1'b0;
            len_r      <= {LEN_W{1'b0}};
            cnt_r      <= {LEN_W{1'b0}};
            adr_r      <= {ADR_W{1'b0}};
            wdat_r     <= {DAT_W{1'b0}};
            rdat_r     <= {DAT_W{1'b0}};
            gnt_r      <= {NCH{1'b0}};
            resp_en_r  <= {NCH{1'b0}};
            resp_dat_r <= {DAT_W{1'b0}};
            ram_dat_r  <= 8'h00;
            rwen_r     <= 1'b0;
        end else if (en) begin
            gnt_r     <= {NCH{1'b0}};
            resp_en_r <= {NCH{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (|grant_s) begin
                        gnt_r     <= grant_s;
                        ptr_r     <= next_ptr_s;
                        ch_r      <= next_ptr_s;
                        io_wr_r   <= sel_rw_s & (sel_adr_s[ADR_W-1 -: 2] == IO_PAGE);
                        len_r     <= clamp_len(sel_len_s, MAXB);
                        cnt_r     <= {LEN_W{1'b0}};
                        adr_r     <= sel_adr_s;
                        ram_dat_r <= sel_dat_s[7:0];
                        wdat_r    <= {8'h00, sel_dat_s[DAT_W-1:8]};
                        rdat_r    <= {DAT_W{1'b0}};
                        rwen_r    <= sel_rw_s;
                        state_r   <= sel_rw_s ? ST_WRITE : ST_READ;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (abort_s) begin
                        rwen_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (last_s) begin
                        resp_en_r  <= NCH'(1'b1) << ch_r;
                        resp_dat_r <= rdat_next_s;
                        adr_r      <= adr_r + ADR_W'(1'b1);
                        state_r    <= ST_IDLE;
                    end else begin
                        rdat_r     <= rdat_next_s;
                        cnt_r      <= cnt_r + LEN_W'(1'b1);
                        adr_r      <= adr_r + ADR_W'(1'b1);
                    end
                end
                ST_WRITE: begin
                    // A full UART buffer holds the current IO byte in place.
                    if (stall_s) begin
                        state_r   <= ST_WRITE;
                    end else if (last_s) begin
                        rwen_r    <= 1'b0;
                        resp_en_r <= NCH'(1'b1) << ch_r;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r     <= cnt_r + LEN_W'(1'b1);
                        adr_r     <= adr_r + ADR_W'(1'b1);
                        ram_dat_r <= wdat_r[7:0];
                        wdat_r    <= {8'h00, wdat_r[DAT_W-1:8]};
                    end
                end
                default: begin
                    rwen_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o      = gnt_r;
    assign bus.resp_en_o  = resp_en_r;
    assign bus.resp_dat_o = resp_dat_r;
    assign bus.ram_dat_o  = ram_dat_r;
    assign bus.ram_adr_o  = adr_r;
    assign bus.ram_rwen_o = rwen_r & en & ~stall_s;

endmodule
